adc_emu_responder: RTL and testbench

- Synthesizable emulator of the LTC2500-class ADC serial port. It is the far end of the protocol that `adc_if` drives: it receives mclk/scka/sdi/sync and answers with drl and sdoa.
- Instantiated in place of a physical ADC for board-level loopback and for bench verification of `uI_adc_if` / `uQ_adc_if`.
- All protocol inputs are asynchronous to clk. They are oversampled, synchronized and edge-detected on clk.

---
 rtl/adc_emu_responder_if.sv | 13 +
 rtl/adc_emu_responder.sv | 181 ++++++++++++++++++
 tb/tb_adc_emu_responder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/adc_emu_responder_if.sv
// Serial pins between the ADC interface (master) and the emulated ADC (slave).
// Pure wiring: no timing or flow control of its own.
interface adc_emu_responder_if;
  logic mclk;
  logic scka;
  logic sdi;
  logic sync;
  logic drl;
  logic sdoa;

  modport master (output mclk, output scka, output sdi, output sync, input drl, input sdoa);
  modport slave  (input mclk, input scka, input sdi, input sync, output drl, output sdoa);
endinterface

// File: rtl/adc_emu_responder.sv
// Emulated LTC2500-class ADC serial port: conversion timing, port-A readout, config capture.
// Pins act 3 clk cycles after they change (2-flop sync + edge register); no flow control.
module adc_emu_responder #(
  parameter int DATA_W    = 24,
  parameter int CFG_W     = 7,
  parameter int CONV_CYC  = 20,
  parameter int RAMP_STEP = 1
) (
  input  logic               clk,
  input  logic               rstn,
  adc_emu_responder_if.slave adc,
  input  logic               use_ext,
  input  logic [DATA_W-1:0]  sample_i,
  output logic [CFG_W-1:0]   cfg_o,
  output logic               cfg_vld,
  output logic [15:0]        conv_cnt,
  output logic [7:0]         abort_cnt
);

  localparam int CNT_W = (CONV_CYC > 2) ? $clog2(CONV_CYC) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_CYC = CNT_W'(CONV_CYC - 1);
  localparam logic [BIT_W-1:0]  DATA_N   = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0]  CFG_N    = BIT_W'(CFG_W);
  localparam logic [DATA_W-1:0] STEP     = DATA_W'(RAMP_STEP);

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

  // Edge-detected pins packed as {sync, scka, mclk}; sdi only needs its level.
  logic [2:0] pin_s1_q, pin_s1_d, pin_s2_q, pin_s2_d, pin_e_q, pin_e_d;
  logic       sdi_s1_q, sdi_s1_d, sdi_s2_q, sdi_s2_d;
  logic [2:0] pin_rise;
  logic       mclk_rise, scka_rise, scka_fall, sync_rise;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  data_sr_q, data_sr_d;
  logic [DATA_W-1:0]  ramp_q, ramp_d;
  logic [CFG_W-1:0]   cfg_sr_q, cfg_sr_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic               cfg_vld_q, cfg_vld_d;
  logic [15:0]        conv_cnt_q, conv_cnt_d;
  logic [7:0]         abort_cnt_q, abort_cnt_d;
  logic               drl_q, drl_d;
  logic               sdoa_q, sdoa_d;
  logic [DATA_W-1:0]  conv_val;

  assign pin_rise  = pin_s2_q & ~pin_e_q;
  assign mclk_rise = pin_rise[0];
  assign scka_rise = pin_rise[1];
  assign sync_rise = pin_rise[2];
  assign scka_fall = ~pin_s2_q[1] & pin_e_q[1];
  assign conv_val  = use_ext ? sample_i : ramp_q;

  always_comb begin
    pin_s1_d    = {adc.sync, adc.scka, adc.mclk};
    pin_s2_d    = pin_s1_q;
    pin_e_d     = pin_s2_q;
    sdi_s1_d    = adc.sdi;
    sdi_s2_d    = sdi_s1_q;
    state_d     = state_q;
    cyc_d       = cyc_q;
    bit_cnt_d   = bit_cnt_q;
    data_sr_d   = data_sr_q;
    ramp_d      = ramp_q;
    cfg_sr_d    = cfg_sr_q;
    cfg_d       = cfg_q;
    cfg_vld_d   = 1'b0;
    conv_cnt_d  = conv_cnt_q;
    abort_cnt_d = abort_cnt_q;
    drl_d       = drl_q;
    sdoa_d      = sdoa_q;

    case (state_q)
      IDLE: begin
        if (mclk_rise) begin
          state_d = CONV;
          cyc_d   = '0;
          drl_d   = 1'b1;
        end
      end
      CONV: begin
        if (cyc_q == LAST_CYC) begin
          data_sr_d  = conv_val;
          ramp_d     = ramp_q + STEP;
          conv_cnt_d = conv_cnt_q + 16'd1;
          bit_cnt_d  = '0;
          cfg_sr_d   = '0;
          drl_d      = 1'b0;
          sdoa_d     = conv_val[DATA_W-1];
          state_d    = SHIFT;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      SHIFT, DONE: begin
        // mclk wins over a coincident scka edge, which is simply dropped.
        if (mclk_rise) begin
          if (bit_cnt_q >= CFG_N) begin
            cfg_d     = cfg_sr_q;
            cfg_vld_d = 1'b1;
          end
          if (state_q == SHIFT && bit_cnt_q < DATA_N && abort_cnt_q != 8'hFF)
            abort_cnt_d = abort_cnt_q + 8'd1;
          state_d = CONV;
          cyc_d   = '0;
          drl_d   = 1'b1;
          sdoa_d  = 1'b0;
        end else if (state_q == SHIFT) begin
          if (scka_rise && bit_cnt_q < DATA_N) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            cfg_sr_d  = {cfg_sr_q[CFG_W-2:0], sdi_s2_q};
          end else if (scka_fall) begin
            // The last bit stays on sdoa until the fall after the final rise.
            if (bit_cnt_q == DATA_N) begin
              sdoa_d  = 1'b0;
              state_d = DONE;
            end else begin
              data_sr_d = data_sr_q << 1;
              sdoa_d    = data_sr_q[DATA_W-2];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A sync rise on the final conversion cycle beats the ramp increment.
    if (sync_rise)
      ramp_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pin_s1_q    <= '0;
      pin_s2_q    <= '0;
      pin_e_q     <= '0;
      sdi_s1_q    <= 1'b0;
      sdi_s2_q    <= 1'b0;
      state_q     <= IDLE;
      cyc_q       <= '0;
      bit_cnt_q   <= '0;
      data_sr_q   <= '0;
      ramp_q      <= '0;
      cfg_sr_q    <= '0;
      cfg_q       <= '0;
      cfg_vld_q   <= 1'b0;
      conv_cnt_q  <= '0;
      abort_cnt_q <= '0;
      drl_q       <= 1'b0;
      sdoa_q      <= 1'b0;
    end else begin
      pin_s1_q    <= pin_s1_d;
      pin_s2_q    <= pin_s2_d;
      pin_e_q     <= pin_e_d;
      sdi_s1_q    <= sdi_s1_d;
      sdi_s2_q    <= sdi_s2_d;
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bit_cnt_q   <= bit_cnt_d;
      data_sr_q   <= data_sr_d;
      ramp_q      <= ramp_d;
      cfg_sr_q    <= cfg_sr_d;
      cfg_q       <= cfg_d;
      cfg_vld_q   <= cfg_vld_d;
      conv_cnt_q  <= conv_cnt_d;
      abort_cnt_q <= abort_cnt_d;
      drl_q       <= drl_d;
      sdoa_q      <= sdoa_d;
    end
  end

  assign adc.drl   = drl_q;
  assign adc.sdoa  = sdoa_q;
  assign cfg_o     = cfg_q;
  assign cfg_vld   = cfg_vld_q;
  assign conv_cnt  = conv_cnt_q;
  assign abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_adc_emu_responder.sv
// Directed bench for adc_emu_responder: drives the serial pins like the ADC interface would
// and checks frames, drl timing, config capture, abort counting, sync and counter wrap.
module tb_adc_emu_responder;
  logic        clk = 1'b0;
  logic        rstn;
  logic        use_ext;
  logic [23:0] sample_i;
  logic [6:0]  cfg_o;
  logic        cfg_vld;
  logic [15:0] conv_cnt;
  logic [7:0]  abort_cnt;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  adc_emu_responder_if bus ();

  adc_emu_responder dut (
    .clk       (clk),
    .rstn      (rstn),
    .adc       (bus.slave),
    .use_ext   (use_ext),
    .sample_i  (sample_i),
    .cfg_o     (cfg_o),
    .cfg_vld   (cfg_vld),
    .conv_cnt  (conv_cnt),
    .abort_cnt (abort_cnt)
  );

  // Raise mclk, then measure how long drl stays high and how many cycles cfg_vld pulses.
  task automatic start_conv(output int width, output int vld_cnt);
    width   = 0;
    vld_cnt = 0;
    bus.mclk = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c == 3) bus.mclk = 1'b0;
      if (cfg_vld) vld_cnt++;
      if (bus.drl) width++;
      else if (width > 0) break;
    end
    bus.mclk = 1'b0;
  endtask

  // Clock out nrises bits; sdoa is sampled just before each scka rise, like the receiver.
  task automatic read_frame(input int nrises, input logic [6:0] sdi_bits, output logic [23:0] word);
    word = '0;
    for (int i = 0; i < nrises; i++) begin
      word    = {word[22:0], bus.sdoa};
      bus.sdi = (i < 7) ? sdi_bits[6-i] : 1'b0;
      bus.scka = 1'b1;
      repeat (4) @(negedge clk);
      bus.scka = 1'b0;
      repeat (4) @(negedge clk);
    end
    bus.sdi = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (4) begin
      @(negedge clk);
      bus.mclk = ~bus.mclk;
      bus.scka = ~bus.scka;
      bus.sdi  = ~bus.sdi;
      bus.sync = ~bus.sync;
      use_ext  = ~use_ext;
    end
    @(negedge clk);
    n_vec++; if (bus.drl !== 1'b0)   begin n_bad++; $display("FAIL reset_drl: got %b want 0", bus.drl); end
    n_vec++; if (bus.sdoa !== 1'b0)  begin n_bad++; $display("FAIL reset_sdoa: got %b want 0", bus.sdoa); end
    n_vec++; if (cfg_o !== 7'h00)    begin n_bad++; $display("FAIL reset_cfg_o: got %h want 00", cfg_o); end
    n_vec++; if (cfg_vld !== 1'b0)   begin n_bad++; $display("FAIL reset_cfg_vld: got %b want 0", cfg_vld); end
    n_vec++; if (conv_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_conv_cnt: got %h want 0", conv_cnt); end
    n_vec++; if (abort_cnt !== 8'h0) begin n_bad++; $display("FAIL reset_abort_cnt: got %h want 0", abort_cnt); end
    bus.mclk = 1'b0; bus.scka = 1'b0; bus.sdi = 1'b0; bus.sync = 1'b0; use_ext = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.drl !== 1'b0)   begin n_bad++; $display("FAIL idle_drl: got %b want 0", bus.drl); end
  endtask

  task automatic test_ramp_frames();
    int w, v;
    logic [23:0] word;
    use_ext = 1'b0;
    for (int f = 0; f < 3; f++) begin
      start_conv(w, v);
      n_vec++; if (w != 20) begin n_bad++; $display("FAIL ramp_drl_width[%0d]: got %0d want 20", f, w); end
      read_frame(24, 7'h00, word);
      n_vec++; if (word !== 24'(f)) begin n_bad++; $display("FAIL ramp_frame[%0d]: got %h want %h", f, word, 24'(f)); end
      n_vec++; if (bus.sdoa !== 1'b0) begin n_bad++; $display("FAIL ramp_sdoa_tail[%0d]: got %b want 0", f, bus.sdoa); end
    end
    n_vec++; if (conv_cnt !== 16'd3) begin n_bad++; $display("FAIL ramp_conv_cnt: got %0d want 3", conv_cnt); end
    n_vec++; if (abort_cnt !== 8'd0) begin n_bad++; $display("FAIL ramp_abort_cnt: got %0d want 0", abort_cnt); end
  endtask

  task automatic test_ext_sample();
    int w, v;
    logic [23:0] word;
    use_ext  = 1'b1;
    sample_i = 24'hA5C3F0;
    start_conv(w, v);
    read_frame(24, 7'h00, word);
    n_vec++; if (word !== 24'hA5C3F0) begin n_bad++; $display("FAIL ext_frame: got %h want a5c3f0", word); end
    n_vec++; if (bus.sdoa !== 1'b0)   begin n_bad++; $display("FAIL ext_sdoa_tail: got %b want 0", bus.sdoa); end
    n_vec++; if (conv_cnt !== 16'd4)  begin n_bad++; $display("FAIL ext_conv_cnt: got %0d want 4", conv_cnt); end
    use_ext = 1'b0;
  endtask

  task automatic test_cfg();
    int w, v;
    logic [23:0] word;
    start_conv(w, v);
    n_vec++; if (v != 1) begin n_bad++; $display("FAIL cfg_full_frame_vld: got %0d want 1", v); end
    read_frame(7, 7'b1011001, word);
    start_conv(w, v);
    n_vec++; if (v != 1)          begin n_bad++; $display("FAIL cfg_vld_pulse: got %0d cycles want 1", v); end
    n_vec++; if (cfg_o !== 7'h59) begin n_bad++; $display("FAIL cfg_value: got %h want 59", cfg_o); end
    n_vec++; if (abort_cnt !== 8'd1) begin n_bad++; $display("FAIL cfg_abort_cnt: got %0d want 1", abort_cnt); end
    read_frame(5, 7'b1111111, word);
    start_conv(w, v);
    n_vec++; if (v != 0)          begin n_bad++; $display("FAIL cfg_short_vld: got %0d cycles want 0", v); end
    n_vec++; if (cfg_o !== 7'h59) begin n_bad++; $display("FAIL cfg_short_keep: got %h want 59", cfg_o); end
  endtask

  task automatic test_abort();
    int w, v;
    logic [23:0] word;
    read_frame(10, 7'h00, word);
    start_conv(w, v);
    n_vec++; if (abort_cnt !== 8'd3) begin n_bad++; $display("FAIL abort_cnt_one: got %0d want 3", abort_cnt); end
    n_vec++; if (w != 20)            begin n_bad++; $display("FAIL abort_drl_width: got %0d want 20", w); end
    read_frame(24, 7'h00, word);
    n_vec++; if (word !== 24'd7)     begin n_bad++; $display("FAIL abort_next_frame: got %h want 000007", word); end
    n_vec++; if (conv_cnt !== 16'd8) begin n_bad++; $display("FAIL abort_conv_cnt: got %0d want 8", conv_cnt); end
    for (int i = 0; i < 300; i++) start_conv(w, v);
    n_vec++; if (abort_cnt !== 8'hFF)  begin n_bad++; $display("FAIL abort_saturate: got %h want ff", abort_cnt); end
    n_vec++; if (conv_cnt !== 16'd308) begin n_bad++; $display("FAIL abort_loop_conv_cnt: got %0d want 308", conv_cnt); end
  endtask

  task automatic test_sync_ramp();
    int w, v;
    logic [23:0] word;
    bus.sync = 1'b1;
    repeat (4) @(negedge clk);
    bus.sync = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) start_conv(w, v);
    // sync pin rises 20 cycles after mclk, landing on the final conversion cycle.
    w = 0;
    bus.mclk = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c == 3)  bus.mclk = 1'b0;
      if (c == 19) bus.sync = 1'b1;
      if (bus.drl) w++;
      else if (w > 0) break;
    end
    bus.sync = 1'b0;
    n_vec++; if (w != 20) begin n_bad++; $display("FAIL sync_drl_width: got %0d want 20", w); end
    read_frame(24, 7'h00, word);
    n_vec++; if (word !== 24'd5) begin n_bad++; $display("FAIL sync_frame_pre_clear: got %h want 000005", word); end
    start_conv(w, v);
    read_frame(24, 7'h00, word);
    n_vec++; if (word !== 24'd0) begin n_bad++; $display("FAIL sync_frame_cleared: got %h want 000000", word); end
    n_vec++; if (conv_cnt !== 16'd315) begin n_bad++; $display("FAIL sync_conv_cnt: got %0d want 315", conv_cnt); end
  endtask

  task automatic test_cnt_wrap();
    int w, v;
    force dut.conv_cnt_q = 16'hFFFF;
    repeat (3) @(negedge clk);
    release dut.conv_cnt_q;
    @(negedge clk);
    start_conv(w, v);
    n_vec++; if (conv_cnt !== 16'h0000) begin n_bad++; $display("FAIL conv_cnt_wrap: got %h want 0000", conv_cnt); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; use_ext = 1'b0; sample_i = '0;
    bus.mclk = 1'b0; bus.scka = 1'b0; bus.sdi = 1'b0; bus.sync = 1'b0;
    @(negedge clk);
    test_reset();
    test_ramp_frames();
    test_ext_sample();
    test_cfg();
    test_abort();
    test_sync_ramp();
    test_cnt_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
